// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word holding buffer for gapless streaming.
// Optional even-parity trailer bit when SER_PARITY_EN is defined.
module bit_serializer #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bitstream,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              sof,
    output logic              eof,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 2);
`ifdef SER_PARITY_EN
    localparam int LEN = DATA_W + 1;
`else
    localparam int LEN = DATA_W;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] sh, hold, sh_adv, load_word;
    logic              hold_full;
    logic [CNT_W-1:0]  cnt;
    logic              data_bit;
    logic              accept, xfer, last, load, hold_wr;
`ifdef SER_PARITY_EN
    logic              par_q;
`endif

    assign accept    = in_valid & in_ready;
    assign xfer      = bit_valid & bit_ready;
    assign last      = xfer & (cnt == LAST);
    // IDLE loads directly; a last-bit transfer reloads from hold or bypasses a fresh word
    assign load      = ((state == IDLE) & accept) | (last & (hold_full | accept));
    assign load_word = hold_full ? hold : in_data;
    assign hold_wr   = accept & (state == SHIFT) & ~last;
    assign sh_adv    = MSB_FIRST ? {sh[DATA_W-2:0], 1'b0} : {1'b0, sh[DATA_W-1:1]};
    assign data_bit  = MSB_FIRST ? sh[DATA_W-1] : sh[0];

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last && !hold_full && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // output logic
    always_comb begin
        bit_valid = (state == SHIFT);
        sof       = bit_valid & (cnt == '0);
        eof       = bit_valid & (cnt == LAST);
        busy      = bit_valid | hold_full;
        in_ready  = ~hold_full;
`ifdef SER_PARITY_EN
        bitstream = (cnt == CNT_W'(DATA_W)) ? par_q : data_bit;
`else
        bitstream = data_bit;
`endif
    end

    // shifter, counter and holding buffer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh        <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else begin
            if (load) begin
                sh  <= load_word;
                cnt <= '0;
            end else if (last) begin
                sh  <= '0;
                cnt <= '0;
            end else if (xfer) begin
                sh  <= sh_adv;
                cnt <= cnt + 1'b1;
            end
            if (load && hold_full) begin
                hold_full <= 1'b0;
            end else if (hold_wr) begin
                hold      <= in_data;
                hold_full <= 1'b1;
            end
        end
    end

`ifdef SER_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  par_q <= 1'b0;
        else if (load) par_q <= ^load_word;
        else if (last) par_q <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer (MSB-first and LSB-first instances).
module tb_bit_serializer;

`ifdef SER_PARITY_EN
    localparam int LEN = 9;
`else
    localparam int LEN = 8;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] in_data_l = 8'h00;
    logic       in_valid = 1'b0;
    logic       bit_ready = 1'b0;
    logic       in_ready, bitstream, bit_valid, sof, eof, busy;
    logic       in_ready_l, bitstream_l, bit_valid_l, sof_l, eof_l, busy_l;

    int tests = 0;
    int fails = 0;

    bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .bitstream(bitstream), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .sof(sof), .eof(eof), .busy(busy)
    );

    bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset_n(reset_n), .in_data(in_data_l), .in_valid(in_valid),
        .in_ready(in_ready_l), .bitstream(bitstream_l), .bit_valid(bit_valid_l),
        .bit_ready(bit_ready), .sof(sof_l), .eof(eof_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // seq lists the expected data bits in wire order, seq[7] first
    task automatic check_stream(input logic [7:0] seq, input logic par, input int lo,
                                input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            logic b;
            b = (i < 8) ? seq[7-i] : par;
            chk($sformatf("%s bit%0d", tag, i), bitstream, b);
            chk($sformatf("%s valid%0d", tag, i), bit_valid, 1'b1);
            chk($sformatf("%s sof%0d", tag, i), sof, (i == 0));
            chk($sformatf("%s eof%0d", tag, i), eof, (i == LEN - 1));
            tick();
        end
    endtask

    initial begin
        // reset state
        #1;
        chk("rst in_ready", in_ready, 1'b1);
        chk("rst bit_valid", bit_valid, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst bitstream", bitstream, 1'b0);
        chk("rst sof", sof, 1'b0);
        chk("rst eof", eof, 1'b0);
        #12 reset_n = 1'b1;
        tick();

        // 1: D0 MSB first, input changes after accept are ignored
        bit_ready = 1'b1;
        in_data = 8'hD0; in_valid = 1'b1;
        chk("t1 in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0; in_data = 8'hFF;
        check_stream(8'b1101_0000, 1'b1, 0, LEN - 1, "t1");
        chk("t1 idle valid", bit_valid, 1'b0);
        chk("t1 idle busy", busy, 1'b0);
        chk("t1 idle sof", sof, 1'b0);

        // 2: back-to-back AA then 55 through the holding buffer
        in_data = 8'hAA; in_valid = 1'b1;
        tick();
        in_data = 8'h55;
        check_stream(8'b1010_1010, 1'b0, 0, 0, "t2a");
        in_valid = 1'b0;
        chk("t2 in_ready held", in_ready, 1'b0);
        chk("t2 busy held", busy, 1'b1);
        check_stream(8'b1010_1010, 1'b0, 1, LEN - 1, "t2a");
        chk("t2 in_ready drained", in_ready, 1'b1);
        check_stream(8'b0101_0101, 1'b0, 0, LEN - 1, "t2b");
        chk("t2 idle valid", bit_valid, 1'b0);

        // 3: F0 with a 3-cycle stall mid-word and a 1-cycle stall on the last bit
        in_data = 8'hF0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_stream(8'b1111_0000, 1'b0, 0, 2, "t3");
        bit_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3 stall bit", bitstream, 1'b1);
            chk("t3 stall valid", bit_valid, 1'b1);
            chk("t3 stall sof", sof, 1'b0);
            chk("t3 stall eof", eof, 1'b0);
        end
        bit_ready = 1'b1;
        check_stream(8'b1111_0000, 1'b0, 3, LEN - 2, "t3");
        bit_ready = 1'b0;
        tick();
        chk("t3 eof stall eof", eof, 1'b1);
        chk("t3 eof stall valid", bit_valid, 1'b1);
        bit_ready = 1'b1;
        check_stream(8'b1111_0000, 1'b0, LEN - 1, LEN - 1, "t3");
        chk("t3 idle valid", bit_valid, 1'b0);

        // 4: async reset mid-word, then a fresh word 81
        in_data = 8'hC3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_stream(8'b1100_0011, 1'b0, 0, 2, "t4");
        #2 reset_n = 1'b0;
        #1;
        chk("t4 async valid", bit_valid, 1'b0);
        chk("t4 async busy", busy, 1'b0);
        chk("t4 async bitstream", bitstream, 1'b0);
        chk("t4 async in_ready", in_ready, 1'b1);
        #2 reset_n = 1'b1;
        tick();
        chk("t4 no resume", bit_valid, 1'b0);
        chk("t4 in_ready", in_ready, 1'b1);
        in_data = 8'h81; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_stream(8'b1000_0001, 1'b0, 0, LEN - 1, "t4");

        // 5: LSB-first instance with 0B, alongside D0 on the MSB-first one
        in_data = 8'hD0; in_data_l = 8'h0B; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        begin
            logic [7:0] seq_l;
            seq_l = 8'b1101_0000;
            for (int i = 0; i < LEN; i++) begin
                logic b;
                b = (i < 8) ? seq_l[7-i] : 1'b1;
                chk($sformatf("t5 lsb bit%0d", i), bitstream_l, b);
                chk($sformatf("t5 lsb sof%0d", i), sof_l, (i == 0));
                chk($sformatf("t5 lsb eof%0d", i), eof_l, (i == LEN - 1));
                chk($sformatf("t5 msb bit%0d", i), bitstream, b);
                tick();
            end
        end
        chk("t5 lsb idle", bit_valid_l, 1'b0);
        chk("t5 lsb busy", busy_l, 1'b0);

        // 6: parity words 07 and 03 (parity bit only in the parity build)
        in_data = 8'h07; in_valid = 1'b1;
        tick();
        in_data = 8'h03;
        check_stream(8'b0000_0111, 1'b1, 0, 0, "t6a");
        in_valid = 1'b0;
        check_stream(8'b0000_0111, 1'b1, 1, LEN - 1, "t6a");
        check_stream(8'b0000_0011, 1'b0, 0, LEN - 1, "t6b");
        chk("t6 idle", bit_valid, 1'b0);

        // 7: bypass on the last-bit edge with an empty holding buffer
        in_data = 8'h3C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_stream(8'b0011_1100, 1'b0, 0, LEN - 2, "t7a");
        in_data = 8'h5A; in_valid = 1'b1;
        chk("t7 in_ready", in_ready, 1'b1);
        check_stream(8'b0011_1100, 1'b0, LEN - 1, LEN - 1, "t7a");
        in_valid = 1'b0;
        check_stream(8'b0101_1010, 1'b0, 0, LEN - 1, "t7b");
        chk("t7 idle", bit_valid, 1'b0);
        chk("t7 busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
